// File: rtl/cdc_clear_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdc_clear_pkg
// Brief    : Phase encoding, initiator states and phase-to-action helpers for
//            the clearable 2-phase CDC clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cdc_clear_pkg;

   typedef enum logic [1:0] {
      PH_IDLE       = 2'd0,
      PH_ISOLATE    = 2'd1,
      PH_CLEAR      = 2'd2,
      PH_POST_CLEAR = 2'd3
   } phase_e;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND_ISO  = 3'd1,
      ST_REL_ISO   = 3'd2,
      ST_SEND_CLR  = 3'd3,
      ST_REL_CLR   = 3'd4,
      ST_SEND_POST = 3'd5,
      ST_REL_POST  = 3'd6
   } init_state_e;

   typedef struct packed {
      logic isolate;
      logic clear;
   } phase_act_t;

   // What a phase means for the local link end.
   function automatic phase_act_t phase_action(input phase_e ph);
      phase_act_t act;
      act.isolate = (ph == PH_ISOLATE) || (ph == PH_CLEAR);
      act.clear   = (ph == PH_CLEAR);
      return act;
   endfunction

   // Local completion condition of a phase; POST_CLEAR needs nothing locally.
   function automatic logic phase_local_ack(input phase_e ph,
                                            input logic   isolate_ack,
                                            input logic   clear_ack);
      logic ack;
      case (ph)
         PH_ISOLATE: ack = isolate_ack;
         PH_CLEAR:   ack = clear_ack;
         default:    ack = 1'b1;
      endcase
      return ack;
   endfunction

   // Phase carried by an initiator state (SEND and RELEASE share it).
   function automatic phase_e state_phase(input init_state_e st);
      phase_e ph;
      case (st)
         ST_SEND_ISO, ST_REL_ISO:   ph = PH_ISOLATE;
         ST_SEND_CLR, ST_REL_CLR:   ph = PH_CLEAR;
         ST_SEND_POST, ST_REL_POST: ph = PH_POST_CLEAR;
         default:                   ph = PH_IDLE;
      endcase
      return ph;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_clear_seq_half_sync.sv
`default_nettype none
// ============================================================================
// Module   : cdc_clear_seq_half_sync
// Brief    : Multi-flop synchronizer for one asynchronous handshake bit.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_clear_seq_half_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   generate
      if (STAGES == 1) begin : g_single
         // Single capture flop.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) r_sync <= 1'b0;
            else         r_sync <= i_d;
         end
      end else begin : g_chain
         // Shift the async bit through the flop chain.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) r_sync <= '0;
            else         r_sync <= {r_sync[STAGES-2:0], i_d};
         end
      end
   endgenerate

   assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_clear_seq_half.sv
`default_nettype none
// ============================================================================
// Module   : cdc_clear_seq_half
// Brief    : One clock-domain half of the isolate/clear/release sequencer for
//            a clearable 2-phase CDC link. Initiator FSM drives the peer via a
//            4-phase req/ack with phase bits; the receiver applies phases sent
//            by the peer. Local actions are the OR of both contributions.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_clear_seq_half
   import cdc_clear_pkg::*;
#(
   parameter int unsigned SYNC_STAGES          = 2,
   parameter bit          CLEAR_ON_ASYNC_RESET = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clear_i,
   output logic       isolate_o,
   input  logic       isolate_ack_i,
   output logic       clear_o,
   input  logic       clear_ack_i,
   output logic       busy_o,
   output logic       async_req_o,
   output logic [1:0] async_phase_o,
   input  logic       async_ack_i,
   input  logic       async_req_i,
   input  logic [1:0] async_phase_i,
   output logic       async_ack_o
);

   localparam init_state_e C_RST_STATE = CLEAR_ON_ASYNC_RESET ? ST_SEND_ISO : ST_IDLE;

   logic        w_req_s, w_ack_s;
   init_state_e r_state, w_state_nxt;
   logic        r_req_q;
   phase_e      r_rx_cap, r_rx_phase, w_rx_phase_nxt;
   logic        r_rx_pend, w_rx_pend_nxt;
   logic        w_ack_nxt, w_req_rise, w_init_local_ack, w_rx_local_ack;
   phase_act_t  w_init_act, w_rx_act;

   logic        r_isolate, r_clear, r_busy, r_req, r_ack;
   phase_e      r_phase;

   cdc_clear_seq_half_sync #(.STAGES(SYNC_STAGES)) u_sync_req (
      .clk_i (clk_i), .rst_ni(rst_ni), .i_d(async_req_i), .o_q(w_req_s)
   );

   cdc_clear_seq_half_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (
      .clk_i (clk_i), .rst_ni(rst_ni), .i_d(async_ack_i), .o_q(w_ack_s)
   );

   // Initiator state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= C_RST_STATE;
      else         r_state <= w_state_nxt;
   end

   // Initiator next state: SEND waits for peer+local ack, RELEASE for ack low.
   always_comb begin
      w_state_nxt      = r_state;
      w_init_local_ack = phase_local_ack(state_phase(r_state), isolate_ack_i, clear_ack_i);
      case (r_state)
         ST_IDLE:      if (clear_i)                     w_state_nxt = ST_SEND_ISO;
         ST_SEND_ISO:  if (w_ack_s && w_init_local_ack) w_state_nxt = ST_REL_ISO;
         ST_REL_ISO:   if (!w_ack_s)                    w_state_nxt = ST_SEND_CLR;
         ST_SEND_CLR:  if (w_ack_s && w_init_local_ack) w_state_nxt = ST_REL_CLR;
         ST_REL_CLR:   if (!w_ack_s)                    w_state_nxt = ST_SEND_POST;
         ST_SEND_POST: if (w_ack_s && w_init_local_ack) w_state_nxt = ST_REL_POST;
         ST_REL_POST:  if (!w_ack_s)                    w_state_nxt = ST_IDLE;
         default:                                       w_state_nxt = ST_IDLE;
      endcase
   end

   // Receiver: capture phase on request rise, ack once the local action holds.
   always_comb begin
      w_req_rise     = w_req_s & ~r_req_q;
      w_rx_local_ack = phase_local_ack(r_rx_cap, isolate_ack_i, clear_ack_i);
      w_ack_nxt      = r_ack ? w_req_s : (r_rx_pend & w_req_s & w_rx_local_ack);
      w_rx_pend_nxt  = r_rx_pend;
      w_rx_phase_nxt = r_rx_phase;
      if (w_req_rise) begin
         w_rx_pend_nxt  = 1'b1;
         w_rx_phase_nxt = (phase_e'(async_phase_i) == PH_POST_CLEAR) ? PH_IDLE
                                                                      : phase_e'(async_phase_i);
      end else if (!r_ack && w_ack_nxt) begin
         w_rx_pend_nxt  = 1'b0;
      end
      w_init_act = phase_action(state_phase(w_state_nxt));
      w_rx_act   = phase_action(w_rx_phase_nxt);
   end

   // Receiver state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_req_q    <= 1'b0;
         r_rx_cap   <= PH_IDLE;
         r_rx_pend  <= 1'b0;
         r_rx_phase <= PH_IDLE;
      end else begin
         r_req_q    <= w_req_s;
         r_rx_pend  <= w_rx_pend_nxt;
         r_rx_phase <= w_rx_phase_nxt;
         if (w_req_rise) r_rx_cap <= phase_e'(async_phase_i);
      end
   end

   // Registered outputs, derived from next-state so they track it with no lag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_isolate <= CLEAR_ON_ASYNC_RESET;
         r_clear   <= 1'b0;
         r_busy    <= CLEAR_ON_ASYNC_RESET;
         r_req     <= 1'b0;
         r_phase   <= PH_IDLE;
         r_ack     <= 1'b0;
      end else begin
         r_isolate <= w_init_act.isolate | w_rx_act.isolate;
         r_clear   <= w_init_act.clear   | w_rx_act.clear;
         r_busy    <= (w_state_nxt != ST_IDLE) || (w_rx_phase_nxt != PH_IDLE);
         r_req     <= (w_state_nxt == ST_SEND_ISO) || (w_state_nxt == ST_SEND_CLR) ||
                      (w_state_nxt == ST_SEND_POST);
         r_phase   <= state_phase(w_state_nxt);
         r_ack     <= w_ack_nxt;
      end
   end

   assign isolate_o     = r_isolate;
   assign clear_o       = r_clear;
   assign busy_o        = r_busy;
   assign async_req_o   = r_req;
   assign async_phase_o = r_phase;
   assign async_ack_o   = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_cdc_clear_seq_half.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_clear_seq_half
// Brief    : Bench for cdc_clear_seq_half with peer BFMs and a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_clear_seq_half;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clear_i, isolate_ack_i, clear_ack_i;
   logic       isolate_o, clear_o, busy_o, async_req_o, async_ack_o;
   logic [1:0] async_phase_o;
   logic       async_ack_i = 1'b0;
   logic       async_req_i = 1'b0;
   logic [1:0] async_phase_i = 2'd0;

   // stimulus mode: random or manual local inputs
   logic rand_en = 1'b0;
   logic man_clear = 1'b0, man_iso_ack = 1'b1, man_clr_ack = 1'b1;
   logic rnd_clear = 1'b0, rnd_iso_ack = 1'b1, rnd_clr_ack = 1'b1;
   assign clear_i       = rand_en ? rnd_clear   : man_clear;
   assign isolate_ack_i = rand_en ? rnd_iso_ack : man_iso_ack;
   assign clear_ack_i   = rand_en ? rnd_clr_ack : man_clr_ack;

   int  n_checks = 0;
   int  n_fail   = 0;
   logic mdl_chk = 1'b0;

   always #5 clk = ~clk;

   cdc_clear_seq_half #(.SYNC_STAGES(SYNC), .CLEAR_ON_ASYNC_RESET(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i),
      .isolate_o(isolate_o), .isolate_ack_i(isolate_ack_i),
      .clear_o(clear_o), .clear_ack_i(clear_ack_i), .busy_o(busy_o),
      .async_req_o(async_req_o), .async_phase_o(async_phase_o),
      .async_ack_i(async_ack_i), .async_req_i(async_req_i),
      .async_phase_i(async_phase_i), .async_ack_o(async_ack_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Initiator is the phase number being worked on (0 = none) plus whether
   // the request has been withdrawn; receiver is the applied peer phase.
   int   m_ph, m_rxph, m_cap;
   logic m_rel, m_pend, m_ack, m_prev;
   logic m_sreq [SYNC];
   logic m_sack [SYNC];
   logic e_req, e_iso, e_clr, e_busy, e_ack;
   int   e_ph;

   function automatic logic local_done(input int ph);
      if (ph == 1) return isolate_ack_i;
      if (ph == 2) return clear_ack_i;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_ph = 1; m_rel = 0; m_rxph = 0; m_cap = 0; m_pend = 0; m_ack = 0; m_prev = 0;
      for (int i = 0; i < SYNC; i++) begin m_sreq[i] = 0; m_sack[i] = 0; end
      e_req = 0; e_ph = 0; e_iso = 1; e_clr = 0; e_busy = 1; e_ack = 0;
   endtask

   task automatic model_step();
      logic ack_s, req_s, ack_new;
      ack_s = m_sack[SYNC-1];
      req_s = m_sreq[SYNC-1];
      if (m_ph == 0) begin
         if (clear_i) begin m_ph = 1; m_rel = 0; end
      end else if (!m_rel) begin
         if (ack_s && local_done(m_ph)) m_rel = 1;
      end else if (!ack_s) begin
         m_ph = (m_ph == 3) ? 0 : m_ph + 1;
         m_rel = 0;
      end
      ack_new = m_ack ? req_s : (m_pend && req_s && local_done(m_cap));
      if (req_s && !m_prev) begin
         m_cap = int'(async_phase_i); m_pend = 1;
         m_rxph = (m_cap == 3) ? 0 : m_cap;
      end else if (ack_new && !m_ack) begin
         m_pend = 0;
      end
      m_ack  = ack_new;
      m_prev = req_s;
      for (int i = SYNC-1; i > 0; i--) begin m_sreq[i] = m_sreq[i-1]; m_sack[i] = m_sack[i-1]; end
      m_sreq[0] = async_req_i;
      m_sack[0] = async_ack_i;
      e_req  = (m_ph != 0) && !m_rel;
      e_ph   = m_ph;
      e_iso  = (m_ph == 1) || (m_ph == 2) || (m_rxph == 1) || (m_rxph == 2);
      e_clr  = (m_ph == 2) || (m_rxph == 2);
      e_busy = (m_ph != 0) || (m_rxph != 0);
      e_ack  = m_ack;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (mdl_chk) begin
         check("req",   32'(async_req_o),   32'(e_req));
         check("phase", 32'(async_phase_o), 32'(e_ph));
         check("iso",   32'(isolate_o),     32'(e_iso));
         check("clr",   32'(clear_o),       32'(e_clr));
         check("busy",  32'(busy_o),        32'(e_busy));
         check("ack_o", 32'(async_ack_o),   32'(e_ack));
      end
   end

   // ---------------- peer BFMs ----------------
   // Peer receiver: its ack follows our req after 0..3 cycles.
   int rsp_cnt = 0, rsp_dly = 0;
   always @(negedge clk) begin
      if (async_ack_i != async_req_o) begin
         if (rsp_cnt >= rsp_dly) begin
            async_ack_i = async_req_o;
            rsp_cnt = 0;
            rsp_dly = $urandom_range(0, 3);
         end else rsp_cnt++;
      end else rsp_cnt = 0;
   end

   // Random local stimulus.
   always @(negedge clk) begin
      rnd_clear   = ($urandom_range(0, 15) == 0);
      rnd_iso_ack = ($urandom_range(0, 3) != 0);
      rnd_clr_ack = ($urandom_range(0, 3) != 0);
   end

   task automatic wait_ack_o(input logic lvl, input string name);
      int k;
      for (k = 0; k < 200 && async_ack_o !== lvl; k++) @(negedge clk);
      check(name, 32'(k >= 200), 32'd0);
   endtask

   // Peer initiator: one full 4-phase transfer of phase p.
   task automatic send_peer(input int p);
      @(negedge clk); async_phase_i = 2'(p);
      @(negedge clk); async_req_i = 1'b1;
      wait_ack_o(1'b1, "peer_ack_hi_timeout");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      async_req_i = 1'b0;
      wait_ack_o(1'b0, "peer_ack_lo_timeout");
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 300 && busy_o !== 1'b0; k++) @(negedge clk);
      check(name, 32'(k >= 300), 32'd0);
   endtask

   // Counts request rises with phase 1 until busy drops; also logs phases.
   task automatic run_and_log(output int n_iso, output int n_tot, output int ph [8]);
      logic prev = 1'b0;
      int k;
      n_iso = 0; n_tot = 0;
      for (k = 0; k < 400; k++) begin
         @(negedge clk);
         if (async_req_o && !prev) begin
            if (n_tot < 8) ph[n_tot] = int'(async_phase_o);
            n_tot++;
            if (async_phase_o == 2'd1) n_iso++;
         end
         prev = async_req_o;
         if (!busy_o && !async_req_o) break;
      end
      check("seq_timeout", 32'(k >= 400), 32'd0);
   endtask

   initial begin
      int n_iso, n_tot, k;
      int ph [8];
      // reset with auto-clear enabled
      repeat (4) @(negedge clk);
      mdl_chk = 1'b1;
      check("rst_iso",  32'(isolate_o),   32'd1);
      check("rst_busy", 32'(busy_o),      32'd1);
      check("rst_req",  32'(async_req_o), 32'd0);
      check("rst_clr",  32'(clear_o),     32'd0);
      check("rst_ack",  32'(async_ack_o), 32'd0);
      #2 rst_n = 1'b1;

      // automatic sequence after reset: phases 1,2,3 in order
      run_and_log(n_iso, n_tot, ph);
      check("auto_nphases", 32'(n_tot), 32'd3);
      check("auto_ph0", 32'(ph[0]), 32'd1);
      check("auto_ph1", 32'(ph[1]), 32'd2);
      check("auto_ph2", 32'(ph[2]), 32'd3);
      check("auto_busy_end", 32'(busy_o), 32'd0);

      // clear pulse with isolate ack held off for 20 cycles
      repeat (3) @(negedge clk);
      man_iso_ack = 1'b0;
      man_clear = 1'b1;
      @(negedge clk); man_clear = 1'b0;
      check("pulse_req", 32'(async_req_o), 32'd1);
      check("pulse_iso", 32'(isolate_o),   32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("stall_req", 32'(async_req_o), 32'd1);
      end
      man_iso_ack = 1'b1;
      wait_idle("pulse_idle_timeout");

      // peer sends CLEAR: clear_o latency, ack gated by clear_ack_i
      repeat (3) @(negedge clk);
      man_clr_ack = 1'b0;
      async_phase_i = 2'd2;
      @(negedge clk); async_req_i = 1'b1;
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (clear_o) break;
      end
      check("rx_clr_latency", 32'(k), 32'(SYNC + 1));
      repeat (5) begin
         @(negedge clk);
         check("rx_ack_gated", 32'(async_ack_o), 32'd0);
      end
      man_clr_ack = 1'b1;
      wait_ack_o(1'b1, "rx_ack_hi_timeout");
      async_req_i = 1'b0;
      wait_ack_o(1'b0, "rx_ack_lo_timeout");
      check("rx_clr_held", 32'(clear_o), 32'd1);
      send_peer(3);
      repeat (2) @(negedge clk);
      check("rx_post_clr",  32'(clear_o),   32'd0);
      check("rx_post_iso",  32'(isolate_o), 32'd0);
      check("rx_post_busy", 32'(busy_o),    32'd0);

      // clear held for 5 cycles: exactly one sequence
      man_clear = 1'b1;
      fork
         begin repeat (5) @(negedge clk); man_clear = 1'b0; end
         run_and_log(n_iso, n_tot, ph);
      join
      check("held_one_seq", 32'(n_iso), 32'd1);

      // reset during SEND(CLEAR)
      man_clr_ack = 1'b0;
      @(negedge clk); man_clear = 1'b1;
      @(negedge clk); man_clear = 1'b0;
      for (k = 0; k < 200 && !(async_req_o && async_phase_o == 2'd2); k++) @(negedge clk);
      check("send_clr_timeout", 32'(k >= 200), 32'd0);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      check("arst_req", 32'(async_req_o), 32'd0);
      check("arst_clr", 32'(clear_o),     32'd0);
      repeat (10) @(negedge clk);
      check("arst_peer_ack", 32'(async_ack_i), 32'd0);
      man_clr_ack = 1'b1;
      #2 rst_n = 1'b1;
      run_and_log(n_iso, n_tot, ph);
      check("arst_restart_ph", 32'(ph[0]), 32'd1);

      // randomized traffic from both sides
      rand_en = 1'b1;
      repeat (40) begin
         repeat ($urandom_range(5, 60)) @(negedge clk);
         for (int p = 1; p <= 3; p++) send_peer(p);
      end
      rand_en = 1'b0;
      wait_idle("drain_timeout");
      repeat (10) @(negedge clk);
      check("final_busy", 32'(busy_o),    32'd0);
      check("final_iso",  32'(isolate_o), 32'd0);

      mdl_chk = 1'b0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // absolute watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
